// File: rtl/line_sched_pkg.sv
// Shared types and default constants for the line-command scheduler.
// Included by the scheduler top and the testbench.
package line_sched_pkg;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [X_W-1:0] x0;
        logic [X_W-1:0] x1;
        logic [Y_W-1:0] y0;
        logic [Y_W-1:0] y1;
        logic           color;
    } line_cmd_t;

    function automatic logic [1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; a lone request always wins,
// ties go to the requester the pointer favours.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (advance) begin
            r_ptr <= ~r_ptr;
        end
    end

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/line_sched.sv
// Shares one line engine between two command sources: arbitrate,
// latch the command, launch the engine, report done or timeout.
module line_sched #(
    parameter int X_W     = line_sched_pkg::X_W,
    parameter int Y_W     = line_sched_pkg::Y_W,
    parameter int TIMEOUT = line_sched_pkg::TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0][X_W-1:0] req_x0,
    input  logic [1:0][X_W-1:0] req_x1,
    input  logic [1:0][Y_W-1:0] req_y0,
    input  logic [1:0][Y_W-1:0] req_y1,
    input  logic [1:0]          req_color,
    output logic [1:0]          cmd_done,
    output logic [1:0]          cmd_err,
    output logic                eng_start,
    output logic [X_W-1:0]      eng_x0,
    output logic [X_W-1:0]      eng_x1,
    output logic [Y_W-1:0]      eng_y0,
    output logic [Y_W-1:0]      eng_y1,
    input  logic                eng_done,
    output logic                pix_color,
    output logic                pix_en,
    output logic                busy,
    output logic                grant_id
);

    import line_sched_pkg::*;

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    sched_state_t   r_state;
    sched_state_t   w_next;
    logic [CW-1:0]  r_cnt;
    logic           r_ok;
    logic           r_gid;
    logic [X_W-1:0] r_x0;
    logic [X_W-1:0] r_x1;
    logic [Y_W-1:0] r_y0;
    logic [Y_W-1:0] r_y1;
    logic           r_color;
    logic [1:0]     w_grant;
    logic           w_win;
    logic           w_accept;
    logic           w_expire;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (r_state == DONE),
        .grant   (w_grant)
    );

    assign w_win    = w_grant[1];
    assign w_accept = (r_state == IDLE) && (|w_grant);
    assign w_expire = (r_cnt == CNT_MAX);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = START;
            START:   w_next = WAIT;
            WAIT:    if (eng_done || w_expire) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ok    <= 1'b0;
            r_gid   <= 1'b0;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_color <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_gid   <= w_win;
                r_x0    <= req_x0[w_win];
                r_x1    <= req_x1[w_win];
                r_y0    <= req_y0[w_win];
                r_y1    <= req_y1[w_win];
                r_color <= req_color[w_win];
            end
            // Saturating: parks at CNT_MAX rather than wrapping.
            if (r_state == START) begin
                r_cnt <= '0;
            end else if (r_state == WAIT && !w_expire) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == WAIT) begin
                r_ok <= eng_done;
            end
        end
    end

    assign req_ready = (r_state == IDLE && !reset) ? w_grant : 2'b00;
    assign eng_start = (r_state == START);
    assign pix_en    = (r_state == START) || (r_state == WAIT);
    assign busy      = (r_state != IDLE);
    assign cmd_done  = (r_state == DONE && r_ok) ? onehot2(r_gid) : 2'b00;
    assign cmd_err   = (r_state == DONE && !r_ok) ? onehot2(r_gid) : 2'b00;
    assign grant_id  = r_gid;
    assign eng_x0    = r_x0;
    assign eng_x1    = r_x1;
    assign eng_y0    = r_y0;
    assign eng_y1    = r_y1;
    assign pix_color = r_color;

endmodule
